tx_word_sequencer: RTL and testbench

//  Controller that sequences the 10-bit word generator and serializes each word onto a bit stream.

---
 rtl/tx_word_sequencer.sv | 158 +++++++++++++++
 tb/tb_tx_word_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_word_sequencer.sv
// Sequences a free-running word generator and serializes each captured word onto a
// valid/ready bit stream, pulsing the generator once per fully transmitted word.
module tx_word_sequencer #(
    parameter int WORD_W     = 10,
    parameter int MSB_FIRST  = 1,
    parameter int GAP_CYCLES = 0,
    parameter int MAX_WORDS  = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_run,
    input  logic [WORD_W-1:0] i_word,
    output logic              o_gen_enable,
    output logic              o_bit,
    output logic              o_bit_valid,
    input  logic              i_bit_ready,
    output logic              o_bit_first,
    output logic              o_bit_last,
    output logic              o_busy,
    output logic              o_done,
    output logic [10:0]       o_words_sent
);

    localparam int BCW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(WORD_W - 1);
    localparam logic [7:0]     GAP_LAST = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);
    localparam logic [10:0]    MAX_CNT  = 11'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_ADV   = 3'd3,
        S_GAP   = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]        gap_cnt_q, gap_cnt_d;
    logic [10:0]       words_q, words_d;

    logic bit_q, bit_d;
    logic valid_q, valid_d;
    logic first_q, first_d;
    logic last_q, last_d;
    logic gen_q, gen_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        words_d   = words_q;

        case (state_q)
            S_IDLE: begin
                if (i_run) state_d = S_LOAD;
            end
            S_LOAD: begin
                shreg_d   = i_word;
                bit_cnt_d = '0;
                state_d   = S_SHIFT;
            end
            S_SHIFT: begin
                // Without ready everything stays put, so the presented bit is held.
                if (i_bit_ready) begin
                    if (MSB_FIRST != 0) shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
                    else                shreg_d = {1'b0, shreg_q[WORD_W-1:1]};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        words_d   = words_q + 11'd1;
                        state_d   = S_ADV;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_ADV: begin
                if ((MAX_WORDS != 0) && (words_q == MAX_CNT)) begin
                    state_d = S_HALT;
                end else if (GAP_CYCLES != 0) begin
                    gap_cnt_d = '0;
                    state_d   = S_GAP;
                end else begin
                    state_d = i_run ? S_LOAD : S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    state_d   = i_run ? S_LOAD : S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            S_HALT: begin
                if (!i_run) begin
                    words_d = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are computed from the next state so they can be registered.
        valid_d = (state_d == S_SHIFT);
        bit_d   = valid_d && ((MSB_FIRST != 0) ? shreg_d[WORD_W-1] : shreg_d[0]);
        first_d = valid_d && (bit_cnt_d == '0);
        last_d  = valid_d && (bit_cnt_d == LAST_BIT);
        gen_d   = (state_d == S_ADV);
        busy_d  = (state_d != S_IDLE) && (state_d != S_HALT);
        done_d  = (state_d == S_HALT);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            words_q   <= '0;
            bit_q     <= 1'b0;
            valid_q   <= 1'b0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
            gen_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            words_q   <= words_d;
            bit_q     <= bit_d;
            valid_q   <= valid_d;
            first_q   <= first_d;
            last_q    <= last_d;
            gen_q     <= gen_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign o_bit        = bit_q;
    assign o_bit_valid  = valid_q;
    assign o_bit_first  = first_q;
    assign o_bit_last   = last_q;
    assign o_gen_enable = gen_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_words_sent = words_q;

endmodule

// File: tb/tb_tx_word_sequencer.sv
// Scoreboard bench for tx_word_sequencer: three configurations (defaults, MAX_WORDS=4
// with a live generator, GAP_CYCLES=3 LSB-first) driven by directed words.
module tb_tx_word_sequencer;

    typedef struct packed {
        logic b;
        logic f;
        logic l;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: defaults
    logic rst_a, run_a, ready_a, gen_a, bit_a, valid_a, first_a, last_a, busy_a, done_a;
    logic [9:0]  word_a;
    logic [10:0] ws_a;
    // Instance B: MAX_WORDS=4, generator modelled in the bench
    logic rst_bc, run_b, ready_b, gen_b, bit_b, valid_b, first_b, last_b, busy_b, done_b;
    logic [9:0]  word_b;
    logic [10:0] ws_b;
    // Instance C: GAP_CYCLES=3, LSB first
    logic run_c, ready_c, gen_c, bit_c, valid_c, first_c, last_c, busy_c, done_c;
    logic [9:0]  word_c;
    logic [10:0] ws_c;

    tx_word_sequencer dut_a (
        .i_clk(clk), .i_rst_n(rst_a), .i_run(run_a), .i_word(word_a),
        .o_gen_enable(gen_a), .o_bit(bit_a), .o_bit_valid(valid_a), .i_bit_ready(ready_a),
        .o_bit_first(first_a), .o_bit_last(last_a), .o_busy(busy_a), .o_done(done_a),
        .o_words_sent(ws_a)
    );

    tx_word_sequencer #(.MAX_WORDS(4)) dut_b (
        .i_clk(clk), .i_rst_n(rst_bc), .i_run(run_b), .i_word(word_b),
        .o_gen_enable(gen_b), .o_bit(bit_b), .o_bit_valid(valid_b), .i_bit_ready(ready_b),
        .o_bit_first(first_b), .o_bit_last(last_b), .o_busy(busy_b), .o_done(done_b),
        .o_words_sent(ws_b)
    );

    tx_word_sequencer #(.GAP_CYCLES(3), .MSB_FIRST(0)) dut_c (
        .i_clk(clk), .i_rst_n(rst_bc), .i_run(run_c), .i_word(word_c),
        .o_gen_enable(gen_c), .o_bit(bit_c), .o_bit_valid(valid_c), .i_bit_ready(ready_c),
        .o_bit_first(first_c), .o_bit_last(last_c), .o_busy(busy_c), .o_done(done_c),
        .o_words_sent(ws_c)
    );

    // Word generator for instance B: advances on each enable pulse.
    always @(posedge clk or negedge rst_bc) begin
        if (!rst_bc)    word_b <= 10'd0;
        else if (gen_b) word_b <= word_b + 10'd1;
    end

    exp_t qa[$], qb[$], qc[$];
    int   fc_a[$], fc_b[$], fc_c[$];
    int   gen_cnt_a = 0, gen_cnt_b = 0, gen_cnt_c = 0;
    int   gen_cyc_a = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic cmp_bit(input string tag, input exp_t e, input logic b, input logic f, input logic l);
        chk({tag, "_bit"}, b, e.b);
        chk({tag, "_first"}, f, e.f);
        chk({tag, "_last"}, l, e.l);
    endtask

    task automatic push_word(input int which, input logic [9:0] w, input bit lsb);
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            e.b = lsb ? w[i] : w[9-i];
            e.f = (i == 0);
            e.l = (i == 9);
            case (which)
                0:       qa.push_back(e);
                1:       qb.push_back(e);
                default: qc.push_back(e);
            endcase
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int gen_count(input int which);
        case (which)
            0:       return gen_cnt_a;
            1:       return gen_cnt_b;
            default: return gen_cnt_c;
        endcase
    endfunction

    task automatic wait_gen(input int which, input int target, input int limit, input string name);
        int n = 0;
        while (gen_count(which) < target && n < limit) begin
            step();
            n++;
        end
        chk({name, "_gen_reached"}, (gen_count(which) >= target), 1);
    endtask

    // Monitors: compare every presented bit against the head of the queue; pop on accept.
    always @(negedge clk) begin
        if (valid_a) begin
            if (qa.size() == 0) chk("A_bit_without_expectation", valid_a, 0);
            else begin
                cmp_bit("A", qa[0], bit_a, first_a, last_a);
                if (ready_a) begin
                    if (qa[0].f) fc_a.push_back(cyc);
                    void'(qa.pop_front());
                end
            end
        end
        if (gen_a) begin
            gen_cnt_a++;
            gen_cyc_a = cyc;
        end
    end

    always @(negedge clk) begin
        if (valid_b) begin
            if (qb.size() == 0) chk("B_bit_without_expectation", valid_b, 0);
            else begin
                cmp_bit("B", qb[0], bit_b, first_b, last_b);
                if (ready_b) begin
                    if (qb[0].f) fc_b.push_back(cyc);
                    void'(qb.pop_front());
                end
            end
        end
        if (gen_b) gen_cnt_b++;
    end

    always @(negedge clk) begin
        if (valid_c) begin
            if (qc.size() == 0) chk("C_bit_without_expectation", valid_c, 0);
            else begin
                cmp_bit("C", qc[0], bit_c, first_c, last_c);
                if (ready_c) begin
                    if (qc[0].f) fc_c.push_back(cyc);
                    void'(qc.pop_front());
                end
            end
        end
        if (gen_c) gen_cnt_c++;
    end

    initial begin
        #800000;
        $display("FAIL watchdog actual=%0d required=%0d", cyc, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int n;
        rst_a = 1'b0; rst_bc = 1'b0;
        run_a = 1'b0; run_b = 1'b0; run_c = 1'b0;
        ready_a = 1'b1; ready_b = 1'b1; ready_c = 1'b1;
        word_a = 10'd0; word_c = 10'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", valid_a, 0);
        chk("rst_bit", bit_a, 0);
        chk("rst_gen", gen_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_b, 0);
        chk("rst_words", ws_a, 0);
        step();
        rst_a = 1'b1; rst_bc = 1'b1;
        repeat (2) step();

        // Single word 0x2A5 with ready held high
        word_a = 10'h2A5;
        push_word(0, 10'h2A5, 1'b0);
        base = cyc; run_a = 1'b1;
        step(); run_a = 1'b0;
        wait_gen(0, 1, 40, "t1");
        chk("t1_first_latency", fc_a[fc_a.size()-1] - base, 2);
        chk("t1_gen_latency", gen_cyc_a - base, 12);
        repeat (3) step();
        chk("t1_words_sent", ws_a, 1);
        chk("t1_busy", busy_a, 0);
        chk("t1_gen_count", gen_cnt_a, 1);
        chk("t1_queue_empty", qa.size(), 0);

        // Backpressure: ready low for 3 cycles once 4 bits are accepted
        word_a = 10'h3C1;
        push_word(0, 10'h3C1, 1'b0);
        base = cyc; run_a = 1'b1;
        step(); run_a = 1'b0;
        repeat (5) step();
        ready_a = 1'b0;
        repeat (3) step();
        ready_a = 1'b1;
        wait_gen(0, 2, 40, "t2");
        chk("t2_gen_latency", gen_cyc_a - base, 15);
        repeat (3) step();
        chk("t2_queue_empty", qa.size(), 0);
        chk("t2_words_sent", ws_a, 2);

        // Run dropped during bit 5: word completes, then idle
        word_a = 10'h155;
        push_word(0, 10'h155, 1'b0);
        base = cyc; run_a = 1'b1;
        repeat (7) step();
        run_a = 1'b0;
        wait_gen(0, 3, 40, "t3");
        repeat (20) step();
        chk("t3_gen_count", gen_cnt_a, 3);
        chk("t3_busy", busy_a, 0);
        chk("t3_words_sent", ws_a, 3);
        chk("t3_queue_empty", qa.size(), 0);

        // Asynchronous reset in the middle of a word
        word_a = 10'h0FF;
        push_word(0, 10'h0FF, 1'b0);
        run_a = 1'b1;
        step(); run_a = 1'b0;
        repeat (4) step();
        #2 rst_a = 1'b0;
        #1;
        chk("t5_valid", valid_a, 0);
        chk("t5_bit", bit_a, 0);
        chk("t5_first", first_a, 0);
        chk("t5_last", last_a, 0);
        chk("t5_busy", busy_a, 0);
        chk("t5_gen", gen_a, 0);
        chk("t5_words_sent", ws_a, 0);
        qa.delete();
        repeat (2) step();
        rst_a = 1'b1;
        repeat (3) step();
        chk("t5_no_gen_after_reset", gen_cnt_a, 3);
        word_a = 10'h0FF;
        push_word(0, 10'h0FF, 1'b0);
        base = cyc; run_a = 1'b1;
        step(); run_a = 1'b0;
        wait_gen(0, 4, 40, "t5");
        chk("t5_restart_first_latency", fc_a[fc_a.size()-1] - base, 2);
        chk("t5_restart_gen_latency", gen_cyc_a - base, 12);
        repeat (2) step();
        chk("t5_restart_words", ws_a, 1);

        // Counter wrap: 2047 more words take o_words_sent from 1 through 2047 to 0
        word_a = 10'h2A5;
        for (int w = 0; w < 2047; w++) push_word(0, 10'h2A5, 1'b0);
        run_a = 1'b1;
        n = 0;
        while (gen_cnt_a < 4 + 2046 && n < 30000) begin
            step();
            n++;
        end
        run_a = 1'b0;
        wait_gen(0, 4 + 2047, 60, "wrap");
        repeat (3) step();
        chk("wrap_words_sent", ws_a, 0);
        chk("wrap_queue_empty", qa.size(), 0);
        chk("wrap_busy", busy_a, 0);

        // MAX_WORDS=4 with the live generator
        for (int w = 0; w < 4; w++) push_word(1, 10'(w), 1'b0);
        run_b = 1'b1;
        wait_gen(1, 4, 100, "t4");
        repeat (30) step();
        chk("t4_gen_count", gen_cnt_b, 4);
        chk("t4_done", done_b, 1);
        chk("t4_busy", busy_b, 0);
        chk("t4_words_sent", ws_b, 4);
        chk("t4_queue_empty", qb.size(), 0);
        chk("t4_valid_in_halt", valid_b, 0);
        run_b = 1'b0;
        step();
        chk("t4_done_cleared", done_b, 0);
        chk("t4_words_cleared", ws_b, 0);

        // GAP_CYCLES=3, LSB first, two back-to-back words
        word_c = 10'h001;
        push_word(2, 10'h001, 1'b1);
        push_word(2, 10'h001, 1'b1);
        base = cyc; run_c = 1'b1;
        n = 0;
        while (fc_c.size() < 2 && n < 60) begin
            step();
            n++;
        end
        run_c = 1'b0;
        wait_gen(2, 2, 40, "t6");
        repeat (20) step();
        chk("t6_first_count", fc_c.size(), 2);
        if (fc_c.size() == 2) begin
            chk("t6_first_latency", fc_c[0] - base, 2);
            chk("t6_word_period", fc_c[1] - fc_c[0], 15);
        end
        chk("t6_gen_count", gen_cnt_c, 2);
        chk("t6_busy", busy_c, 0);
        chk("t6_words_sent", ws_c, 2);
        chk("t6_queue_empty", qc.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
